// File: rtl/register_access_controller_pkg.sv
// Shared definitions for the register access controller: FSM state encoding, default
// frame opcodes and a counter-width helper. Imported by the controller, its timeout
// counter, the system top and the bench.
package register_access_controller_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWrAddr = 3'd1,
        StWrData = 3'd2,
        StRdAddr = 3'd3,
        StRdWait = 3'd4,
        StTxWait = 3'd5
    } state_e;

    localparam logic [7:0]  DEFAULT_WRITE_CMD      = 8'hAA;
    localparam logic [7:0]  DEFAULT_READ_CMD       = 8'hBB;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1023;

    // Bits needed to hold every value 0..max_count inclusive.
    function automatic int unsigned count_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/register_access_controller_if.sv
// Bundle of the controller's byte-stream and register-file signals.
//   master : the controller side (drives strobes, address, write data, tx byte, error)
//   slave  : the environment side (uart rx/tx and register file)
interface register_access_controller_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_data_valid;
    logic [ADDR_WIDTH-1:0] address;
    logic                  write_enable;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  read_enable;
    logic [DATA_WIDTH-1:0] read_data;
    logic                  read_data_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_data_valid;
    logic                  tx_busy;
    logic                  cmd_error;

    modport master (
        input  rx_data, rx_data_valid, read_data, read_data_valid, tx_busy,
        output address, write_enable, write_data, read_enable, tx_data, tx_data_valid,
               cmd_error
    );

    modport slave (
        output rx_data, rx_data_valid, read_data, read_data_valid, tx_busy,
        input  address, write_enable, write_data, read_enable, tx_data, tx_data_valid,
               cmd_error
    );

endinterface

// File: rtl/register_access_controller_frame_timeout_counter.sv
// Idle-cycle counter guarding frame reception and read completion.
//   clk     : system clock
//   reset   : asynchronous, active-low
//   clear   : restart counting from zero (state entry or accepted byte)
//   enable  : count this cycle
//   expired : high while enabled with the count at TIMEOUT_CYCLES; the owner leaves the
//             counting state on it, so it lasts one cycle
module frame_timeout_counter
    import register_access_controller_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CountWidth = count_width(TIMEOUT_CYCLES);
    localparam logic [CountWidth-1:0] Limit = CountWidth'(TIMEOUT_CYCLES);

    logic [CountWidth-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != Limit)) begin
            count_d = count_q + CountWidth'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Independent of clear so the FSM can give a same-cycle rx byte priority without a loop.
    assign expired = enable && (count_q == Limit);

endmodule

// File: rtl/register_access_controller.sv
// Command-side master for the register file. Decodes UART byte frames
// (write: CMD,ADDR,DATA; read: CMD,ADDR), issues single-cycle register strobes and
// returns read data to the UART transmitter.
//   clk   : system clock, all logic on posedge
//   reset : asynchronous, active-low
//   bus   : master modport -- rx byte in, register address/strobes/write data out,
//           register read data in, tx byte out, tx_busy in, cmd_error out
// All outputs are registered.
module register_access_controller
    import register_access_controller_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH          = 8,
    parameter int unsigned           REGISTER_FILE_DEPTH = 16,
    parameter logic [DATA_WIDTH-1:0] WRITE_CMD           = DATA_WIDTH'(DEFAULT_WRITE_CMD),
    parameter logic [DATA_WIDTH-1:0] READ_CMD            = DATA_WIDTH'(DEFAULT_READ_CMD),
    parameter int unsigned           TIMEOUT_CYCLES      = DEFAULT_TIMEOUT_CYCLES
) (
    input logic                          clk,
    input logic                          reset,
    register_access_controller_if.master bus
);

    localparam int unsigned ADDR_WIDTH = $clog2(REGISTER_FILE_DEPTH);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  write_enable_q, write_enable_d;
    logic                  read_enable_q, read_enable_d;
    logic                  tx_data_valid_q, tx_data_valid_d;
    logic                  cmd_error_q, cmd_error_d;

    logic rx_accept;
    logic addr_ok;
    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    frame_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .expired(timer_expired)
    );

    // Address byte must not reach past the register file.
    assign addr_ok = ((bus.rx_data >> ADDR_WIDTH) == '0);

    always_comb begin
        state_d         = state_q;
        address_d       = address_q;
        write_data_d    = write_data_q;
        tx_data_d       = tx_data_q;
        write_enable_d  = 1'b0;
        read_enable_d   = 1'b0;
        tx_data_valid_d = 1'b0;
        cmd_error_d     = 1'b0;
        rx_accept       = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.rx_data_valid) begin
                    rx_accept = 1'b1;
                    if (bus.rx_data == WRITE_CMD) begin
                        state_d = StWrAddr;
                    end else if (bus.rx_data == READ_CMD) begin
                        state_d = StRdAddr;
                    end
                end
            end
            StWrAddr, StRdAddr: begin
                // An rx byte in the expiry cycle beats the timeout.
                if (bus.rx_data_valid) begin
                    rx_accept = 1'b1;
                    if (!addr_ok) begin
                        cmd_error_d = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        address_d = bus.rx_data[ADDR_WIDTH-1:0];
                        if (state_q == StWrAddr) begin
                            state_d = StWrData;
                        end else begin
                            read_enable_d = 1'b1;
                            state_d       = StRdWait;
                        end
                    end
                end else if (timer_expired) begin
                    cmd_error_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StWrData: begin
                if (bus.rx_data_valid) begin
                    rx_accept      = 1'b1;
                    write_data_d   = bus.rx_data;
                    write_enable_d = 1'b1;
                    state_d        = StIdle;
                end else if (timer_expired) begin
                    cmd_error_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StRdWait: begin
                if (bus.read_data_valid) begin
                    tx_data_d = bus.read_data;
                    state_d   = StTxWait;
                end else if (timer_expired) begin
                    cmd_error_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StTxWait: begin
                if (!bus.tx_busy) begin
                    tx_data_valid_d = 1'b1;
                    state_d         = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign timer_enable = (state_q == StWrAddr) || (state_q == StWrData) ||
                          (state_q == StRdAddr) || (state_q == StRdWait);
    assign timer_clear  = (state_d != state_q) || rx_accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= StIdle;
            address_q       <= '0;
            write_data_q    <= '0;
            tx_data_q       <= '0;
            write_enable_q  <= 1'b0;
            read_enable_q   <= 1'b0;
            tx_data_valid_q <= 1'b0;
            cmd_error_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            address_q       <= address_d;
            write_data_q    <= write_data_d;
            tx_data_q       <= tx_data_d;
            write_enable_q  <= write_enable_d;
            read_enable_q   <= read_enable_d;
            tx_data_valid_q <= tx_data_valid_d;
            cmd_error_q     <= cmd_error_d;
        end
    end

    assign bus.address       = address_q;
    assign bus.write_data    = write_data_q;
    assign bus.tx_data       = tx_data_q;
    assign bus.write_enable  = write_enable_q;
    assign bus.read_enable   = read_enable_q;
    assign bus.tx_data_valid = tx_data_valid_q;
    assign bus.cmd_error     = cmd_error_q;

endmodule

// File: tb/tb_register_access_controller.sv
// Bench for register_access_controller: frame-level reference model feeding a scoreboard,
// a register-file responder, and a monitor that pops and compares every DUT output event.
module tb_register_access_controller;
    import register_access_controller_pkg::*;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;
    localparam int          TO    = 1023;

    typedef enum int {EvWrite = 0, EvRead = 1, EvTx = 2, EvErr = 3} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;   // expected monitor cycle, -1 = any
    } ev_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ev_t  sb[$];
    logic [7:0] shadow [DEPTH];
    logic [7:0] rf_mem [DEPTH];
    bit   rf_mute   = 1'b0;
    bit   busy_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    register_access_controller_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    register_access_controller #(
        .DATA_WIDTH         (DW),
        .REGISTER_FILE_DEPTH(DEPTH),
        .WRITE_CMD          (8'hAA),
        .READ_CMD           (8'hBB),
        .TIMEOUT_CYCLES     (TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input ev_kind_e k, input logic [7:0] a, input logic [7:0] d,
                        input int c);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        sb.push_back(e);
    endtask

    task automatic take(input ev_kind_e kind, input logic [7:0] addr, input logic [7:0] data);
        ev_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_%s: got addr 0x%0h data 0x%0h at cycle %0d, expected none",
                     kind.name(), addr, data, cyc);
            return;
        end
        e = sb.pop_front();
        check("event_kind", kind, e.kind);
        if (kind == EvWrite || kind == EvRead) check("address", addr, e.addr);
        if (kind == EvWrite || kind == EvTx) check("data", data, e.data);
        if (e.cyc >= 0) check("event_cycle", cyc, e.cyc);
    endtask

    // Monitor: compares every output event against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                if (bus.write_enable || bus.read_enable)
                    check("strobe_exclusive", bus.write_enable & bus.read_enable, 0);
                if (bus.write_enable) take(EvWrite, 8'(bus.address), bus.write_data);
                if (bus.read_enable) take(EvRead, 8'(bus.address), 8'h00);
                if (bus.tx_data_valid) begin
                    check("tx_busy_gate", busy_prev, 0);
                    take(EvTx, 8'h00, bus.tx_data);
                end
                if (bus.cmd_error) take(EvErr, 8'h00, 8'h00);
            end
            busy_prev = bus.tx_busy;
        end
    end

    // Register file: applies writes, answers reads after 1..3 cycles.
    initial begin
        logic [3:0] a;
        int         lat;
        bus.read_data       = '0;
        bus.read_data_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && bus.write_enable) rf_mem[bus.address] = bus.write_data;
            if (reset && bus.read_enable && !rf_mute) begin
                a   = bus.address;
                lat = $urandom_range(0, 2);
                @(posedge clk);
                #1;
                repeat (lat) begin
                    @(posedge clk);
                    #1;
                end
                bus.read_data       = rf_mem[a];
                bus.read_data_valid = 1'b1;
                @(posedge clk);
                #1;
                bus.read_data_valid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data       = b;
        bus.rx_data_valid = 1'b1;
        tick();
        bus.rx_data_valid = 1'b0;
        bus.rx_data       = 8'($urandom);
    endtask

    task automatic drain(input int bound);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d events still pending after %0d cycles, expected 0",
                     sb.size(), bound);
            sb.delete();
        end
    endtask

    task automatic wr_frame(input logic [7:0] a, input logic [7:0] d, input int gap);
        send_byte(8'hAA);
        repeat (gap) tick();
        send_byte(a);
        repeat (gap) tick();
        push(EvWrite, a, d, cyc + 1);
        shadow[a[3:0]] = d;
        send_byte(d);
    endtask

    task automatic rd_frame(input logic [7:0] a, input int gap, input int busy_len);
        send_byte(8'hBB);
        repeat (gap) tick();
        if (busy_len > 0) bus.tx_busy = 1'b1;
        push(EvRead, a, 8'h00, cyc + 1);
        push(EvTx, 8'h00, shadow[a[3:0]], -1);
        send_byte(a);
        repeat (busy_len) tick();
        bus.tx_busy = 1'b0;
        drain(60);
    endtask

    task automatic bad_frame(input logic [7:0] cmd, input logic [7:0] a);
        send_byte(cmd);
        push(EvErr, 8'h00, 8'h00, cyc + 1);
        send_byte(a);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish by cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         e;
        int         sel;
        logic [7:0] a;
        logic [7:0] b;

        bus.rx_data       = '0;
        bus.rx_data_valid = 1'b0;
        bus.tx_busy       = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            shadow[i] = 8'($urandom);
            rf_mem[i] = shadow[i];
        end
        shadow[2] = 8'h01;
        rf_mem[2] = 8'h01;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_address", bus.address, 0);
        check("rst_write_enable", bus.write_enable, 0);
        check("rst_write_data", bus.write_data, 0);
        check("rst_read_enable", bus.read_enable, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_tx_data_valid", bus.tx_data_valid, 0);
        check("rst_cmd_error", bus.cmd_error, 0);
        tick();
        reset = 1'b1;
        repeat (2) tick();

        // Basic write, then back-to-back read of register 2
        wr_frame(8'h05, 8'h3C, 0);
        rd_frame(8'h02, 0, 0);

        // Read with tx_busy held; bytes in RD_WAIT and TX_WAIT are dropped
        send_byte(8'hBB);
        bus.tx_busy = 1'b1;
        e = cyc + 1;
        push(EvRead, 8'h02, 8'h00, e);
        push(EvTx, 8'h00, shadow[2], e + 21);
        send_byte(8'h02);
        send_byte(8'hAA);
        wait_until(e + 10);
        send_byte(8'hBB);
        wait_until(e + 20);
        bus.tx_busy = 1'b0;
        drain(20);

        // Bad address, then an ignored byte, then a normal write
        bad_frame(8'hAA, 8'h1F);
        send_byte(8'h55);
        wr_frame(8'h0A, 8'hC3, 1);
        bad_frame(8'hBB, 8'h10);

        // Timeout in WR_ADDR, then a normal read
        send_byte(8'hAA);
        push(EvErr, 8'h00, 8'h00, cyc + TO + 1);
        repeat (TO + 5) tick();
        drain(5);
        rd_frame(8'h03, 1, 2);

        // Byte arriving in the expiry cycle wins
        send_byte(8'hAA);
        repeat (TO) tick();
        send_byte(8'h06);
        push(EvWrite, 8'h06, 8'h5A, cyc + 1);
        shadow[6] = 8'h5A;
        send_byte(8'h5A);
        rd_frame(8'h06, 0, 1);

        // Timeout waiting for read data
        rf_mute = 1'b1;
        send_byte(8'hBB);
        e = cyc + 1;
        push(EvRead, 8'h09, 8'h00, e);
        push(EvErr, 8'h00, 8'h00, e + TO + 1);
        send_byte(8'h09);
        repeat (TO + 5) tick();
        rf_mute = 1'b0;
        drain(5);

        // Reset mid-frame aborts it
        send_byte(8'hAA);
        send_byte(8'h07);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_address", bus.address, 0);
        check("midrst_write_enable", bus.write_enable, 0);
        check("midrst_write_data", bus.write_data, 0);
        check("midrst_read_enable", bus.read_enable, 0);
        check("midrst_tx_data", bus.tx_data, 0);
        check("midrst_tx_data_valid", bus.tx_data_valid, 0);
        check("midrst_cmd_error", bus.cmd_error, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        send_byte(8'h99);
        repeat (5) tick();
        wr_frame(8'h07, 8'h99, 0);

        // Randomized frames
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            a   = 8'($urandom_range(0, DEPTH - 1));
            if (sel < 4) begin
                wr_frame(a, 8'($urandom), $urandom_range(0, 3));
            end else if (sel < 7) begin
                rd_frame(a, $urandom_range(0, 3), $urandom_range(0, 6));
            end else if (sel == 7) begin
                bad_frame(($urandom_range(0, 1) == 0) ? 8'hAA : 8'hBB,
                          8'($urandom_range(16, 255)));
            end else begin
                b = 8'($urandom);
                while (b == 8'hAA || b == 8'hBB) b = 8'($urandom);
                send_byte(b);
            end
            repeat ($urandom_range(0, 2)) tick();
        end

        drain(50);
        repeat (5) tick();
        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
